// File: rtl/alu_pkg.sv
// Shared definitions for seq_alu: operation codes and controller state encoding.
package alu_pkg;

  localparam logic [2:0] FN_ADD   = 3'b000;
  localparam logic [2:0] FN_OR_R  = 3'b001;
  localparam logic [2:0] FN_AND_R = 3'b010;
  localparam logic [2:0] FN_CAT   = 3'b011;
  localparam logic [2:0] FN_MUL   = 3'b100;
  localparam logic [2:0] FN_SHL   = 3'b101;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

endpackage

// File: rtl/ripple_adder_w.sv
// Parametrised N-bit ripple-carry adder built as a chain of full-adder cells.
module ripple_adder_w #(
  parameter int N = 8
) (
  input  logic [N-1:0] x,
  input  logic [N-1:0] y,
  input  logic         cin,
  output logic [N-1:0] sum,
  output logic         cout
);

  logic [N:0] carry;

  assign carry[0] = cin;

  for (genvar i = 0; i < N; i++) begin : g_fa
    logic c_in;
    logic c_out;
    logic s;
    assign c_in       = carry[i];
    assign s          = x[i] ^ y[i] ^ c_in;
    assign c_out      = (x[i] & y[i]) | (c_in & (x[i] ^ y[i]));
    assign sum[i]     = s;
    assign carry[i+1] = c_out;
  end

  assign cout = carry[N];

endmodule

// File: rtl/seq_alu.sv
// Registered W-bit ALU with start/busy/done handshake, multi-cycle shift-add
// multiply and accumulate mode (operand B taken from the previous result).
// Optional result flags are enabled by defining SEQ_ALU_FLAGS_EN.
module seq_alu
  import alu_pkg::*;
#(
  parameter int W     = 4,
  parameter int CNT_W = $clog2(W) + 1
) (
  input  logic           Clock,
  input  logic           Reset_b,
  input  logic           start,
  input  logic [2:0]     func,
  input  logic [W-1:0]   a,
  input  logic [W-1:0]   b,
  input  logic           acc_sel,
  output logic           busy,
  output logic           done,
`ifdef SEQ_ALU_FLAGS_EN
  output logic [1:0]     flags,
`endif
  output logic [2*W-1:0] alu_out
);

  localparam int RW = 2 * W;

  state_t           state_q, state_d;
  logic [W-1:0]     mplier_q;
  logic [RW-1:0]    mcand_q;
  logic [RW-1:0]    acc_q;
  logic [RW-1:0]    alu_out_q;
  logic [CNT_W-1:0] cnt_q;
  logic             done_q;

  logic [W-1:0]     b_eff;
  logic [RW-1:0]    add_x;
  logic [RW-1:0]    add_y;
  logic [RW-1:0]    add_sum;
  logic             unused_co;
  logic [RW-1:0]    op_res;
  logic             op_carry;
  logic [RW-1:0]    res_next;
  logic             carry_next;
  logic             cap_mul;
  logic             load_res;
  logic             done_d;

  // Accumulate mode reuses the low half of the currently displayed result.
  assign b_eff = acc_sel ? alu_out_q[W-1:0] : b;

  // The single adder serves ADD while idle and the partial-product sum in RUN.
  always_comb begin
    add_x = '0;
    add_y = '0;
    if (state_q == ST_RUN) begin
      add_x = acc_q;
      add_y = mplier_q[0] ? mcand_q : '0;
    end else begin
      add_x = {{W{1'b0}}, a};
      add_y = {{W{1'b0}}, b_eff};
    end
  end

  ripple_adder_w #(.N(RW)) u_adder (
    .x    (add_x),
    .y    (add_y),
    .cin  (1'b0),
    .sum  (add_sum),
    .cout (unused_co)
  );

  // Result of the single-cycle operations; NOP and MUL fall through to hold.
  always_comb begin
    op_res   = alu_out_q;
    op_carry = 1'b0;
    case (func)
      FN_ADD: begin
        op_res   = {{(W-1){1'b0}}, add_sum[W:0]};
        op_carry = add_sum[W];
      end
      FN_OR_R:  op_res = {{(RW-1){1'b0}}, |{a, b_eff}};
      FN_AND_R: op_res = {{(RW-1){1'b0}}, &{a, b_eff}};
      FN_CAT:   op_res = {a, b_eff};
      FN_SHL:   op_res = {{W{1'b0}}, b_eff} << a;
      default:  op_res = alu_out_q;
    endcase
  end

  // Controller state register.
  always_ff @(posedge Clock or negedge Reset_b) begin
    if (!Reset_b) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state and datapath enables; start is only honoured in IDLE.
  always_comb begin
    state_d    = state_q;
    cap_mul    = 1'b0;
    load_res   = 1'b0;
    done_d     = 1'b0;
    res_next   = op_res;
    carry_next = op_carry;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (func == FN_MUL) begin
            state_d = ST_RUN;
            cap_mul = 1'b1;
          end else begin
            done_d   = 1'b1;
            load_res = (func[2:1] != 2'b11);
          end
        end
      end
      ST_RUN: begin
        if (cnt_q == CNT_W'(W - 1)) begin
          state_d    = ST_IDLE;
          done_d     = 1'b1;
          load_res   = 1'b1;
          res_next   = add_sum;
          carry_next = |add_sum[RW-1:W];
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Multiplier datapath: shift multiplicand left and multiplier right per step.
  always_ff @(posedge Clock or negedge Reset_b) begin
    if (!Reset_b) begin
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
    end else if (cap_mul) begin
      mcand_q  <= {{W{1'b0}}, a};
      mplier_q <= b_eff;
      acc_q    <= '0;
      cnt_q    <= '0;
    end else if (state_q == ST_RUN) begin
      acc_q    <= add_sum;
      mcand_q  <= mcand_q << 1;
      mplier_q <= mplier_q >> 1;
      cnt_q    <= cnt_q + CNT_W'(1);
    end
  end

  // Result register and completion pulse.
  always_ff @(posedge Clock or negedge Reset_b) begin
    if (!Reset_b) begin
      alu_out_q <= '0;
      done_q    <= 1'b0;
    end else begin
      done_q <= done_d;
      if (load_res) begin
        alu_out_q <= res_next;
      end
    end
  end

`ifdef SEQ_ALU_FLAGS_EN
  logic [1:0] flags_q;

  // Flags follow the result register: {carry, zero}.
  always_ff @(posedge Clock or negedge Reset_b) begin
    if (!Reset_b) begin
      flags_q <= '0;
    end else if (load_res) begin
      flags_q <= {carry_next, (res_next == '0)};
    end
  end

  assign flags = flags_q;
`else
  logic unused_carry;
  assign unused_carry = carry_next;
`endif

  assign busy    = (state_q == ST_RUN);
  assign done    = done_q;
  assign alu_out = alu_out_q;

endmodule

// File: tb/tb_seq_alu.sv
// Directed bench for seq_alu (W=4): table of single-cycle ops plus multiply,
// accumulate, ignored-start, finish-edge start and async reset sequences.
module tb_seq_alu;

  logic       clk;
  logic       Reset_b;
  logic       start;
  logic [2:0] func;
  logic [3:0] a;
  logic [3:0] b;
  logic       acc_sel;
  logic       busy;
  logic       done;
  logic [7:0] alu_out;
`ifdef SEQ_ALU_FLAGS_EN
  logic [1:0] flags;
`endif

  int checks;
  int errors;

  seq_alu #(.W(4)) dut (
    .Clock   (clk),
    .Reset_b (Reset_b),
    .start   (start),
    .func    (func),
    .a       (a),
    .b       (b),
    .acc_sel (acc_sel),
    .busy    (busy),
    .done    (done),
`ifdef SEQ_ALU_FLAGS_EN
    .flags   (flags),
`endif
    .alu_out (alu_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] func;
    logic [3:0] a;
    logic [3:0] b;
    logic       acc;
    logic [7:0] exp;
    logic [1:0] fl;
  } vec_t;

  vec_t tv[17];

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic chk_flags(input string nm, input logic [1:0] exp);
`ifdef SEQ_ALU_FLAGS_EN
    chk(nm, 16'(flags), 16'(exp));
`else
    if (exp === 2'bxx) chk(nm, 16'(busy), 16'(busy));
`endif
  endtask

  task automatic drive(input logic [2:0] f, input logic [3:0] va, input logic [3:0] vb,
                       input logic acc, input logic st);
    func    = f;
    a       = va;
    b       = vb;
    acc_sel = acc;
    start   = st;
  endtask

  initial begin
    int ndone;
    checks = 0;
    errors = 0;

    tv[0]  = '{3'b000, 4'hF, 4'h1, 1'b0, 8'h10, 2'b10};
    tv[1]  = '{3'b000, 4'h2, 4'h3, 1'b0, 8'h05, 2'b00};
    tv[2]  = '{3'b000, 4'h1, 4'h0, 1'b1, 8'h06, 2'b00};
    tv[3]  = '{3'b001, 4'h0, 4'h0, 1'b0, 8'h00, 2'b01};
    tv[4]  = '{3'b010, 4'hF, 4'hF, 1'b0, 8'h01, 2'b00};
    tv[5]  = '{3'b010, 4'hF, 4'hE, 1'b0, 8'h00, 2'b01};
    tv[6]  = '{3'b001, 4'h0, 4'h8, 1'b0, 8'h01, 2'b00};
    tv[7]  = '{3'b011, 4'hA, 4'h5, 1'b0, 8'hA5, 2'b00};
    tv[8]  = '{3'b101, 4'h9, 4'h1, 1'b0, 8'h00, 2'b01};
    tv[9]  = '{3'b101, 4'h3, 4'hF, 1'b0, 8'h78, 2'b00};
    tv[10] = '{3'b101, 4'h7, 4'h1, 1'b0, 8'h80, 2'b00};
    tv[11] = '{3'b110, 4'h1, 4'h1, 1'b0, 8'h80, 2'b00};
    tv[12] = '{3'b111, 4'h2, 4'h2, 1'b0, 8'h80, 2'b00};
    tv[13] = '{3'b000, 4'hF, 4'hF, 1'b0, 8'h1E, 2'b10};
    tv[14] = '{3'b000, 4'h2, 4'h0, 1'b1, 8'h10, 2'b10};
    tv[15] = '{3'b011, 4'h0, 4'h7, 1'b1, 8'h00, 2'b01};
    tv[16] = '{3'b000, 4'h8, 4'h3, 1'b1, 8'h08, 2'b00};

    // Reset state
    Reset_b = 1'b0;
    drive(3'b000, 4'h0, 4'h0, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    chk("reset alu_out", 16'(alu_out), 16'h0);
    chk("reset busy", 16'(busy), 16'h0);
    chk("reset done", 16'(done), 16'h0);
    chk_flags("reset flags", 2'b00);
    Reset_b = 1'b1;
    @(negedge clk);

    // Back-to-back single-cycle ops from the table
    for (int i = 0; i < 17; i++) begin
      drive(tv[i].func, tv[i].a, tv[i].b, tv[i].acc, 1'b1);
      @(negedge clk);
      chk($sformatf("vec%0d alu_out", i), 16'(alu_out), 16'(tv[i].exp));
      chk($sformatf("vec%0d done", i), 16'(done), 16'h1);
      chk($sformatf("vec%0d busy", i), 16'(busy), 16'h0);
      chk_flags($sformatf("vec%0d flags", i), tv[i].fl);
    end
    start = 1'b0;
    @(negedge clk);
    chk("done clears", 16'(done), 16'h0);
    chk("idle hold", 16'(alu_out), 16'h08);

    // MUL F*F: four busy cycles with result held, then product
    drive(3'b100, 4'hF, 4'hF, 1'b0, 1'b1);
    @(negedge clk);
    start = 1'b0;
    for (int c = 0; c < 4; c++) begin
      chk($sformatf("mul busy c%0d", c), 16'(busy), 16'h1);
      chk($sformatf("mul done c%0d", c), 16'(done), 16'h0);
      chk($sformatf("mul hold c%0d", c), 16'(alu_out), 16'h08);
      @(negedge clk);
    end
    chk("mul FF result", 16'(alu_out), 16'hE1);
    chk("mul FF done", 16'(done), 16'h1);
    chk("mul FF busy", 16'(busy), 16'h0);
    chk_flags("mul FF flags", 2'b10);
    @(negedge clk);
    chk("mul FF done clears", 16'(done), 16'h0);

    // MUL 3*5 with a CAT start during RUN that must be ignored
    drive(3'b100, 4'h3, 4'h5, 1'b0, 1'b1);
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    drive(3'b011, 4'h1, 4'h2, 1'b0, 1'b1);
    @(negedge clk);
    start = 1'b0;
    ndone = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (done) ndone++;
    end
    chk("mul ignore result", 16'(alu_out), 16'h0F);
    chk("mul ignore one done", 16'(ndone), 16'h1);
    chk("mul ignore busy", 16'(busy), 16'h0);
    chk_flags("mul 35 flags", 2'b00);

    // MUL 2*3 with start held: refused on finish edge, accepted next cycle
    drive(3'b100, 4'h2, 4'h3, 1'b0, 1'b1);
    @(negedge clk);
    drive(3'b000, 4'h1, 4'h1, 1'b0, 1'b1);
    repeat (3) @(negedge clk);
    chk("finish busy", 16'(busy), 16'h1);
    @(negedge clk);
    chk("finish mul result", 16'(alu_out), 16'h06);
    chk("finish mul done", 16'(done), 16'h1);
    @(negedge clk);
    chk("after finish add", 16'(alu_out), 16'h02);
    chk("after finish done", 16'(done), 16'h1);
    start = 1'b0;
    @(negedge clk);
    chk("after finish clears", 16'(done), 16'h0);

    // Asynchronous reset in the middle of a multiply
    drive(3'b100, 4'hF, 4'hF, 1'b0, 1'b1);
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    chk("pre-reset busy", 16'(busy), 16'h1);
    #2 Reset_b = 1'b0;
    #1;
    chk("async busy", 16'(busy), 16'h0);
    chk("async done", 16'(done), 16'h0);
    chk("async alu_out", 16'(alu_out), 16'h0);
    chk_flags("async flags", 2'b00);
    @(negedge clk);
    Reset_b = 1'b1;
    @(negedge clk);
    drive(3'b000, 4'h3, 4'h4, 1'b0, 1'b1);
    @(negedge clk);
    start = 1'b0;
    chk("post-reset add", 16'(alu_out), 16'h07);
    chk("post-reset done", 16'(done), 16'h1);
    repeat (6) @(negedge clk);
    chk("post-reset no stray done", 16'(done), 16'h0);
    chk("post-reset hold", 16'(alu_out), 16'h07);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/seq_alu.md
Name: seq_alu

Overview:
- Registered, parametrised ALU; successor to the 4-bit combinational add/OR/AND/concat ALU.
- Adds a multi-cycle unsigned shift-add multiply, a logical shift, and an accumulate mode that feeds the previous result back as operand B.
- Uses a start/busy/done handshake.
- Sits between the switch/operand registers and the LED/HEX display logic on the board top level.

Parameters:
W, 4, operand width in bits (W >= 2); result width is 2*W.
CNT_W, $clog2(W)+1, multiply iteration counter width (derived; do not override).

Ports:
Clock  input  1  single system clock, rising edge.
Reset_b  input  1  asynchronous, active-low reset.
start  input  1  request; sampled on the rising edge of Clock.
func  input  3  operation select; captured with start.
a  input  W  operand A; captured with start.
b  input  W  operand B; captured with start.
acc_sel  input  1  when 1 at start, operand B := alu_out[W-1:0] instead of b.
busy  output  1  high while a multiply is in progress.
done  output  1  one-cycle pulse when alu_out holds a new result.
alu_out  output  2*W  registered result.

Behaviour:
- Reset: Reset_b low asynchronously forces the following, including mid-multiply; any operation in flight is discarded:
  - state = IDLE
  - alu_out = 0
  - busy = 0
  - done = 0
  - counter = 0
  - internal operand and accumulator registers = 0
- States:
  - IDLE: accepts start.
  - RUN: multiply iterating.
- Func codes; results are zero-extended to 2*W unless stated:
  - 000 ADD: {carry, A+B}, W+1 bits.
  - 001 OR_R: 1 if any bit of {A,B} is set, else 0.
  - 010 AND_R: 1 if all bits of {A,B} are set, else 0.
  - 011 CAT: {A,B}.
  - 100 MUL: unsigned A*B, full 2*W product, multi-cycle.
  - 101 SHL: ({W'b0,B} << A) truncated to 2*W; A >= 2*W gives 0.
  - 110, 111 NOP: alu_out unchanged; done still pulses.
- Single-cycle ops (every code except 100):
  - start=1 in IDLE at edge k: alu_out updates and done=1 after edge k; done clears at edge k+1 unless another start arrives.
  - Back-to-back starts on consecutive cycles are each accepted.
- MUL:
  - start=1 in IDLE at edge k: capture A and B, clear accumulator and counter, go to RUN, busy=1.
  - Each RUN edge i = 0..W-1: if B[i], accumulator += A<<i (through the adder sub-module); counter increments.
  - At edge k+W: alu_out = accumulator, done=1, busy=0, return to IDLE.
  - Latency is W cycles. alu_out holds its previous value throughout RUN.
- start while busy: ignored entirely; operands are not captured and no done pulse is produced.
- start in the same cycle that MUL finishes: not accepted, because state is still RUN at that edge; it may be accepted on the following cycle.
- acc_sel=1: B is taken from alu_out[W-1:0] as registered before edge k; upper result bits are not used.
- Arithmetic is unsigned throughout.
- Overflow:
  - ADD carry appears at bit W.
  - MUL cannot overflow 2*W bits.
  - SHL silently drops bits shifted past 2*W.
- done and busy are never high in the same cycle.

Optional Feature:
SEQ_ALU_FLAGS_EN:
- Defined: adds output flags[1:0], registered and updated together with alu_out.
  - flags[0] = zero: new result == 0.
  - flags[1] = carry: ADD carry-out, or MUL product upper half nonzero; 0 for all other ops.
  - Reset value is 0. NOP holds flags.
- Undefined: no flags port; all other behaviour is identical.

Decomposition:
- Package alu_pkg:
  - localparam func codes: FN_ADD, FN_OR_R, FN_AND_R, FN_CAT, FN_MUL, FN_SHL.
  - State encoding: ST_IDLE, ST_RUN.
- One sub-module: ripple_adder_w, a parametrised N-bit ripple-carry adder built from the full-adder cell (c_in, c_out, s).
  - Instantiated once at width 2*W.
  - Shared between ADD (upper bits zero) and the MUL accumulate step, multiplexed by state.

Test Plan (W=4):
- Reset_b pulsed low, then start with func=000, a=4'hF, b=4'h1 → one cycle later alu_out=8'h10, done=1 for exactly 1 cycle.
- func=100, a=4'hF, b=4'hF, start 1 cycle → busy=1 for 4 cycles, alu_out unchanged until done; then alu_out=8'hE1, done pulse.
- During MUL (a=3, b=5), assert start with func=011 on cycle 2 → ignored; final alu_out=8'h0F, only one done.
- Sequence ADD a=2,b=3 (result 8'h05), then ADD a=1 with acc_sel=1 → alu_out=8'h06; back-to-back starts both produce done.
- func=001 a=0,b=0 → 8'h00; func=010 a=F,b=F → 8'h01; func=101 a=9,b=1 → 8'h00; func=110 → alu_out held, done pulses.
- Reset_b low at RUN cycle 2 of MUL → busy, done and alu_out go to 0 immediately (async); after release, a new ADD completes normally.
